polybius_code_serializer: RTL
=============================

# polybius_code_serializer

Downstream stage of the Polybius encrypter: accepts one 8-bit decimal-valued Polybius code per symbol (11..55, or 0 for "not found") through a valid/ready handshake, buffers codes in a small FIFO, and emits them as a printable ASCII byte stream. Each code becomes two digit characters followed by a separator, or CR LF on the last symbol of a message. It sits between the combinational encrypter and the byte transmitter (UART TX / display path).

## Interface
- FIFO_DEPTH, 4, input code buffer depth; power of two, ≥2
- SEP, 8'h20, separator byte emitted after each non-last symbol
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_code/in_last valid
- in_ready  out  1  FIFO can accept (= !full && !rst)
- in_code  in  8  Polybius code; binary value of a two-digit decimal number
- in_last  in  1  symbol is last of message; terminate with CR LF instead of SEP
- out_valid  out  1  out_byte valid
- out_ready  in  1  consumer accepts out_byte
- out_byte  out  8  ASCII output byte
- busy  out  1  FIFO non-empty or FSM not IDLE
- err_pulse  out  1  one-cycle pulse when an invalid code is popped

One clock; reset is asynchronous and active-high.

## Operation
- Push on in_valid && in_ready; FIFO stores {in_last, in_code} (9 bits). in_ready is not pop-aware: when full it stays 0 even if a pop occurs that cycle.
- Code validity: tens = in_code/10, units = in_code%10; valid iff both in 1..5 (11–15, 21–25, …, 51–55). Everything else, including 0, is invalid. No divider; split by compare chain.
- FSM states: IDLE, TENS, UNITS, ERR, SEP, CR, LF.
- IDLE: if FIFO non-empty, pop; valid → TENS (out_byte = 8'h30+tens); invalid → ERR (out_byte = 8'h3F '?'), err_pulse = 1 that cycle.
- TENS → UNITS (8'h30+units) on handshake.
- UNITS or ERR → on handshake: last=0 → SEP (out_byte = SEP); last=1 → CR (8'h0D).
- CR → LF (8'h0A) on handshake.
- SEP or LF → on handshake: FIFO non-empty → pop and go directly to TENS/ERR (no bubble); else IDLE.
- States advance only on out_valid && out_ready; out_valid = 1 in every state except IDLE.
- Simultaneous push and pop: count unchanged; push into an empty FIFO is not visible to the FSM until the next cycle.

## Timing
- Reset values: out_valid 0, out_byte 8'h00, in_ready 0 while rst is high and 1 on the first cycle after release, busy 0, err_pulse 0. FSM → IDLE, FIFO pointers and count cleared.
- out_byte and out_valid are registered. Latency: code accepted at edge k into an empty FIFO with FSM IDLE → first byte valid after edge k+1.
- Throughput with out_ready held 1: one byte per cycle, continuous across symbols. 3 bytes per valid non-last symbol, 4 per valid last symbol; 2 or 3 respectively for invalid symbols.
- Backpressure: while out_valid && !out_ready, out_byte and the state are held stable. The FIFO keeps accepting until full.
- Reset mid-symbol: the remainder of the symbol and all buffered codes are discarded; out_valid drops asynchronously.

## Structure
- Shared package polybius_pkg: ASCII constants (ZERO 8'h30, QMARK 8'h3F, CR 8'h0D, LF 8'h0A, SPACE 8'h20), the FSM state encoding, and code-range constants (MIN_DIGIT 1, MAX_DIGIT 5).
- One sub-module, polybius_code_split: combinational, in_code → tens[2:0], units[2:0], valid. Reused by the future decrypt path.
- FIFO is inline: circular buffer, pointers of log2(FIFO_DEPTH) bits, separate count register of log2(FIFO_DEPTH)+1 bits.

## Test plan
- Reset: assert rst mid-stream → out_valid 0, out_byte 8'h00, busy 0 immediately; after release, in_ready = 1 on the next cycle.
- Push 23, last=0, out_ready=1 → 8'h32, 8'h33, 8'h20 on three consecutive cycles, first valid one cycle after the accept edge, then IDLE.
- Push 55, last=1 → 8'h35, 8'h35, 8'h0D, 8'h0A; err_pulse never asserted.
- Push 0 and then 16, last=0 → 8'h3F, 8'h20, 8'h3F, 8'h20 back-to-back; err_pulse high for exactly 2 single cycles.
- out_ready=0, offer 5 codes (11, 12, 13, 14, 15) with FIFO_DEPTH=4 → first 4 accepted (one popped into FSM, so the 5th is accepted one cycle later); in_ready then 0; out_byte held at 8'h31. Release → stream "11 12 13 14 15 " in order, no bubbles.
- Reset after '1' of code 14 handshaken, with 2 codes buffered → no 8'h34 emitted, FIFO empty; new push 31 → 8'h33, 8'h31, 8'h20.

Source files
------------

// File: rtl/polybius_pkg.sv
// Shared constants for the Polybius encrypt/decrypt paths: ASCII bytes, digit range
// and the serializer FSM state encoding.
package polybius_pkg;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] QMARK = 8'h3F;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] SPACE = 8'h20;

    localparam logic [2:0] MIN_DIGIT = 3'd1;
    localparam logic [2:0] MAX_DIGIT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TENS,
        ST_UNITS,
        ST_ERR,
        ST_SEP,
        ST_CR,
        ST_LF
    } state_t;

endpackage

// File: rtl/polybius_code_split.sv
// Splits a binary-valued two-digit Polybius code into its decimal digits and flags
// whether both digits lie in the grid range.
module polybius_code_split
    import polybius_pkg::*;
(
    input  logic [7:0] code,
    output logic [2:0] tens,
    output logic [2:0] units,
    output logic       valid
);

    logic [7:0] rem;

    // Compare chain instead of a divider; anything >= 60 is rejected outright.
    always_comb begin
        tens = '0;
        rem  = code;
        if (code >= 8'd50) begin
            tens = 3'd5;
            rem  = code - 8'd50;
        end else if (code >= 8'd40) begin
            tens = 3'd4;
            rem  = code - 8'd40;
        end else if (code >= 8'd30) begin
            tens = 3'd3;
            rem  = code - 8'd30;
        end else if (code >= 8'd20) begin
            tens = 3'd2;
            rem  = code - 8'd20;
        end else if (code >= 8'd10) begin
            tens = 3'd1;
            rem  = code - 8'd10;
        end
        valid = (code < 8'd60)
             && (tens >= MIN_DIGIT) && (tens <= MAX_DIGIT)
             && (rem >= {5'd0, MIN_DIGIT}) && (rem <= {5'd0, MAX_DIGIT});
        units = rem[2:0];
    end

endmodule

// File: rtl/polybius_code_serializer.sv
// Buffers Polybius codes in a small FIFO and emits each as two ASCII digits plus a
// separator, or CR LF at end of message; invalid codes become '?'.
module polybius_code_serializer
    import polybius_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  SEP        = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_code,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       busy,
    output logic       err_pulse
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;
    logic [8:0]    head;
    logic [2:0]    h_tens, h_units;
    logic          h_valid;

    state_t     state, next_state;
    logic [7:0] next_byte;
    logic       cur_last, next_last;
    logic [2:0] cur_units, next_units;
    logic       hs, load;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign head      = mem[rd_ptr];
    assign out_valid = (state != ST_IDLE);
    assign busy      = !empty || (state != ST_IDLE);
    assign hs        = out_valid && out_ready;

    polybius_code_split u_split (
        .code  (head[7:0]),
        .tens  (h_tens),
        .units (h_units),
        .valid (h_valid)
    );

    always_comb begin
        next_state = state;
        next_byte  = out_byte;
        next_last  = cur_last;
        next_units = cur_units;
        load       = 1'b0;
        pop        = 1'b0;
        err_pulse  = 1'b0;
        case (state)
            ST_IDLE: load = !empty;
            ST_TENS: if (hs) begin
                next_state = ST_UNITS;
                next_byte  = ZERO + {5'd0, cur_units};
            end
            ST_UNITS, ST_ERR: if (hs) begin
                next_state = cur_last ? ST_CR : ST_SEP;
                next_byte  = cur_last ? CR : SEP;
            end
            ST_CR: if (hs) begin
                next_state = ST_LF;
                next_byte  = LF;
            end
            ST_SEP, ST_LF: if (hs) begin
                if (!empty) load = 1'b1;
                else        next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        // Popping straight from SEP/LF keeps the byte stream gap-free across symbols.
        if (load) begin
            pop        = 1'b1;
            next_last  = head[8];
            next_units = h_units;
            if (h_valid) begin
                next_state = ST_TENS;
                next_byte  = ZERO + {5'd0, h_tens};
            end else begin
                next_state = ST_ERR;
                next_byte  = QMARK;
                err_pulse  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_byte  <= '0;
            cur_last  <= 1'b0;
            cur_units <= '0;
        end else begin
            state     <= next_state;
            out_byte  <= next_byte;
            cur_last  <= next_last;
            cur_units <= next_units;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_last, in_code};
    end

endmodule
